multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle control FSM for the LEGv8 subset (LDUR, STUR, CBZ, CBNZ, ADD, SUB, AND, ORR, ADDI). It replaces single-cycle decode with a sequenced controller driving a shared ALU, a single unified memory port with a ready handshake, and the IR/PC/OldPC/ALUOut registers. It sits between the instruction register opcode field and the multi-cycle datapath.

## Interface
- TIMEOUT_CYCLES, 255: max wait cycles for mem_ready in FETCH/MEMACC; 0 disables timeout.
- CNT_W, 32: perf counter width (only with MCCTRL_PERF_EN).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Op  in  11  IR[31:21]; stable from DECODE onward.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory accepts/completes the current request this cycle.
- PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemtoReg, Reg2Loc, IorD, PCSrc  out  1 each  datapath controls. IorD: 0=PC, 1=ALUOut. PCSrc: 0=ALU result, 1=ALUOut.
- ALUSrcA  out  1  0=OldPC/PC, 1=register A.
- ALUSrcB  out  2  00=reg B, 01=const 4, 10=sign-extended imm, 11=branch offset <<2.
- ALUOp  out  2  00=add, 01=pass B, 10=funct-decoded.
- instr_done  out  1  one-cycle pulse on instruction retirement.
- error  out  1  sticky; high in ERROR.
- ctrl_state  out  3  current state encoding.

## Operation
- States: FETCH, DECODE, EXEC, MEMACC, WB, ERROR. Reset state FETCH.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00. On mem_ready: IRWrite=1, PCWrite=1, PCSrc=0, -> DECODE; else stay.
- DECODE: ALUSrcA=0 (OldPC), ALUSrcB=11, ALUOp=00 (target -> ALUOut). Classify Op: LDUR 11111000010, STUR 11111000000, CBZ 10110100xxx, CBNZ 10110101xxx, ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, ADDI 1001000100x. Unmatched -> ERROR; else -> EXEC. Reg2Loc=1 for STUR/CBZ/CBNZ in DECODE and EXEC.
- EXEC: LDUR/STUR: A=1, B=10, ALUOp=00 -> MEMACC. R-type: A=1, B=00, ALUOp=10 -> WB. ADDI: A=1, B=10, ALUOp=10 -> WB. CBZ/CBNZ: B=00, ALUOp=01; taken = (CBZ&Zero)|(CBNZ&!Zero); if taken, PCWrite=1, PCSrc=1; instr_done=1; -> FETCH.
- MEMACC: IorD=1; MemRead=1 (LDUR) or MemWrite=1 (STUR); held until mem_ready. Then LDUR -> WB; STUR -> FETCH with instr_done.
- WB: RegWrite=1, MemtoReg=1 for LDUR else 0; instr_done=1; -> FETCH.
- ERROR: all controls 0, error=1; exits only via reset.
- Timeout: wait counter clears on entering FETCH/MEMACC and increments each cycle mem_ready is low; reaching TIMEOUT_CYCLES -> ERROR. mem_ready in the same cycle wins.
- Opcode class is registered in DECODE; EXEC/MEMACC/WB use the registered class.

## Timing
- While reset is low: state=FETCH, all outputs 0, including MemRead, with async gating. First FETCH request is in the first cycle after release.
- Reset mid-MEMACC aborts immediately; MemWrite drops asynchronously.
- IRWrite/PCWrite in FETCH and MEMACC completion are Mealy on mem_ready. All other outputs are Moore on state/class.
- Zero-wait latency: CB 3 cycles, R/ADDI/STUR 4, LDUR 5. Each mem_ready-low cycle adds 1.
- No instruction overlap; instr_done is never asserted in consecutive cycles.

## Configuration
- MCCTRL_PERF_EN defined: adds outputs cycle_cnt and retired_cnt (CNT_W each). Both reset to 0. cycle_cnt increments every non-ERROR cycle; retired_cnt increments on instr_done. Both wrap modulo 2^CNT_W.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- mcctrl_pkg: state enum, opcode-class enum, opcode constants/masks, ALUSrcB and ALUOp encodings.
- Sub-module mc_opclass: combinational Op -> class (LDUR, STUR, CBZ, CBNZ, RTYPE, ADDI, ILLEGAL).

## Test plan
- ADD (Op=10001011000), mem_ready tied 1 -> states FETCH,DECODE,EXEC,WB; RegWrite=1 only in WB; instr_done at cycle 4.
- LDUR, mem_ready low 3 cycles in MEMACC -> MemRead held 4 cycles; 8 cycles total; MemtoReg=1 in WB.
- CBZ, Zero=1 -> PCWrite=1, PCSrc=1 in EXEC. CBNZ, Zero=1 -> PCWrite=0. Both retire at cycle 3.
- Op=00000000000 -> ERROR after DECODE; error=1 held; reset recovers to FETCH.
- TIMEOUT_CYCLES=4, mem_ready stuck low in FETCH -> ERROR after 4 wait cycles. A second run with mem_ready rising on the 4th wait cycle -> proceeds to DECODE.
- STUR with reset asserted mid-MEMACC -> MemWrite 0 same cycle; FETCH after release. With MCCTRL_PERF_EN, retired_cnt wraps from 2^CNT_W-1 to 0.

Source files
------------

// File: rtl/mcctrl_pkg.sv
// mcctrl_pkg -- shared types and encodings for the LEGv8 multi-cycle controller.
//   state_t    : controller state encoding (also driven onto ctrl_state)
//   opclass_t  : instruction class derived from IR[31:21]
//   OP_*/MASK_*: opcode match values and don't-care masks
//   SRCB_*     : ALUSrcB mux encodings
//   ALUOP_*    : ALUOp encodings
//   ctrl_t     : bundle of datapath control strobes before reset gating
package mcctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEMACC = 3'd3,
    ST_WB     = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_ILLEGAL = 3'd0,
    CL_LDUR    = 3'd1,
    CL_STUR    = 3'd2,
    CL_CBZ     = 3'd3,
    CL_CBNZ    = 3'd4,
    CL_RTYPE   = 3'd5,
    CL_ADDI    = 3'd6
  } opclass_t;

  // Opcode values; low bits covered by a zero in the mask are don't-care.
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ = 11'b10110101000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;

  localparam logic [10:0] MASK_FULL = 11'b11111111111;
  localparam logic [10:0] MASK_CB   = 11'b11111111000; // CB format: Op[2:0] belong to the offset
  localparam logic [10:0] MASK_ADDI = 11'b11111111110; // I format: Op[0] belongs to the immediate

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg2loc;
    logic       i_or_d;
    logic       pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctrl_t;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] value,
                                    input logic [10:0] mask);
    return (op & mask) == value;
  endfunction

  // Store and compare-branch read their second operand from Rt (IR[4:0]).
  function automatic logic uses_rt(input opclass_t cls);
    return (cls == CL_STUR) || (cls == CL_CBZ) || (cls == CL_CBNZ);
  endfunction

endpackage

// File: rtl/mc_opclass.sv
// mc_opclass -- combinational opcode classifier.
//   op       in  11  IR[31:21]
//   op_class out 3   opclass_t encoding; CL_ILLEGAL when nothing matches
module mc_opclass
  import mcctrl_pkg::*;
(
  input  logic [10:0] op,
  output logic [2:0]  op_class
);

  opclass_t cls;

  // NOTE: every always_comb output gets a default first so no path can hold
  // a previous value, which would otherwise infer a latch.
  always_comb begin
    cls = CL_ILLEGAL;
    if (op_match(op, OP_LDUR, MASK_FULL))      cls = CL_LDUR;
    else if (op_match(op, OP_STUR, MASK_FULL)) cls = CL_STUR;
    else if (op_match(op, OP_CBZ, MASK_CB))    cls = CL_CBZ;
    else if (op_match(op, OP_CBNZ, MASK_CB))   cls = CL_CBNZ;
    else if (op_match(op, OP_ADD, MASK_FULL) ||
             op_match(op, OP_SUB, MASK_FULL) ||
             op_match(op, OP_AND, MASK_FULL) ||
             op_match(op, OP_ORR, MASK_FULL))  cls = CL_RTYPE;
    else if (op_match(op, OP_ADDI, MASK_ADDI)) cls = CL_ADDI;
  end

  assign op_class = cls;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- sequencing controller for a multi-cycle LEGv8 datapath
// (LDUR, STUR, CBZ, CBNZ, ADD, SUB, AND, ORR, ADDI) with one shared ALU and
// one unified memory port using a mem_ready handshake.
//
// Parameters:
//   TIMEOUT_CYCLES  max mem_ready wait in FETCH/MEMACC before ERROR (0 = never)
//   CNT_W           perf counter width (present only with MCCTRL_PERF_EN)
// Ports:
//   clk, reset (async, active-low)
//   Op[10:0]        IR[31:21], stable from DECODE onward
//   Zero            ALU zero flag (consulted in EXEC for CBZ/CBNZ)
//   mem_ready       memory completes/accepts the current request this cycle
//   PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemtoReg, Reg2Loc, IorD,
//   PCSrc, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0]   datapath controls
//   instr_done      one-cycle pulse on retirement
//   error           high while in ERROR (left only through reset)
//   ctrl_state[2:0] current state_t encoding
// Build option:
//   MCCTRL_PERF_EN  adds cycle_cnt / retired_cnt outputs (CNT_W bits each)
module multicycle_ctrl
  import mcctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
`ifdef MCCTRL_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Op,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        Reg2Loc,
  output logic        IorD,
  output logic        PCSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        instr_done,
  output logic        error,
  output logic [2:0]  ctrl_state
`ifdef MCCTRL_PERF_EN
  , output logic [CNT_W-1:0] cycle_cnt
  , output logic [CNT_W-1:0] retired_cnt
`endif
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t            state, state_next;
  opclass_t          dec_class, cls_q;
  logic [2:0]        dec_class_raw;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              timeout_hit;
  logic              taken;
  ctrl_t             ctrl, ctrl_g;
  logic              error_raw;

  mc_opclass u_opclass (
    .op       (Op),
    .op_class (dec_class_raw)
  );

  assign dec_class = opclass_t'(dec_class_raw);

  // ---------------------------------------------------------------------------
  // State register and registered opcode class
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_FETCH;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  cls_q <= CL_ILLEGAL;
    else if (state == ST_DECODE) cls_q <= dec_class;
  end

  // ---------------------------------------------------------------------------
  // Memory wait counter: zero on every state change, so each FETCH/MEMACC
  // visit starts its own budget. A cycle with mem_ready high never times out.
  // ---------------------------------------------------------------------------
  assign waiting = ((state == ST_FETCH) || (state == ST_MEMACC)) && !mem_ready;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       ((32'(wait_cnt) + 32'd1) >= TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   wait_cnt <= '0;
    else if (state_next != state) wait_cnt <= '0;
    else if (waiting)             wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Next state and controls
  // ---------------------------------------------------------------------------
  assign taken = ((cls_q == CL_CBZ) && Zero) || ((cls_q == CL_CBNZ) && !Zero);

  always_comb begin
    state_next = state;
    ctrl       = '0;
    error_raw  = 1'b0;

    case (state)
      ST_FETCH: begin
        ctrl.i_or_d    = 1'b0;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = 1'b0;
          state_next    = ST_DECODE;
        end else if (timeout_hit) begin
          state_next = ST_ERROR;
        end
      end

      ST_DECODE: begin
        // Branch target OldPC + (offset << 2) is parked in ALUOut.
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_BR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.reg2loc   = uses_rt(dec_class);
        state_next     = (dec_class == CL_ILLEGAL) ? ST_ERROR : ST_EXEC;
      end

      ST_EXEC: begin
        ctrl.reg2loc = uses_rt(cls_q);
        case (cls_q)
          CL_LDUR, CL_STUR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
            state_next     = ST_MEMACC;
          end
          CL_RTYPE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALUOP_FUNCT;
            state_next     = ST_WB;
          end
          CL_ADDI: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_FUNCT;
            state_next     = ST_WB;
          end
          CL_CBZ, CL_CBNZ: begin
            // ALU passes Rt through to produce Zero; the target is already in ALUOut.
            ctrl.alu_src_b  = SRCB_REG;
            ctrl.alu_op     = ALUOP_PASSB;
            ctrl.pc_write   = taken;
            ctrl.pc_src     = taken;
            ctrl.instr_done = 1'b1;
            state_next      = ST_FETCH;
          end
          default: state_next = ST_ERROR;
        endcase
      end

      ST_MEMACC: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_read  = (cls_q == CL_LDUR);
        ctrl.mem_write = (cls_q == CL_STUR);
        if (mem_ready) begin
          if (cls_q == CL_LDUR) begin
            state_next = ST_WB;
          end else begin
            ctrl.instr_done = 1'b1;
            state_next      = ST_FETCH;
          end
        end else if (timeout_hit) begin
          state_next = ST_ERROR;
        end
      end

      ST_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = (cls_q == CL_LDUR);
        ctrl.instr_done = 1'b1;
        state_next      = ST_FETCH;
      end

      ST_ERROR: error_raw = 1'b1;

      default: state_next = ST_ERROR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs are forced low combinationally while reset is asserted, so an
  // in-flight memory request is withdrawn without waiting for a clock.
  // ---------------------------------------------------------------------------
  assign ctrl_g = reset ? ctrl : '0;

  assign PCWrite    = ctrl_g.pc_write;
  assign IRWrite    = ctrl_g.ir_write;
  assign RegWrite   = ctrl_g.reg_write;
  assign MemRead    = ctrl_g.mem_read;
  assign MemWrite   = ctrl_g.mem_write;
  assign MemtoReg   = ctrl_g.mem_to_reg;
  assign Reg2Loc    = ctrl_g.reg2loc;
  assign IorD       = ctrl_g.i_or_d;
  assign PCSrc      = ctrl_g.pc_src;
  assign ALUSrcA    = ctrl_g.alu_src_a;
  assign ALUSrcB    = ctrl_g.alu_src_b;
  assign ALUOp      = ctrl_g.alu_op;
  assign instr_done = ctrl_g.instr_done;
  assign error      = reset & error_raw;
  assign ctrl_state = state;

`ifdef MCCTRL_PERF_EN
  // Free-running counters; both wrap modulo 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (state != ST_ERROR) cycle_cnt   <= cycle_cnt + CNT_W'(1);
      if (ctrl.instr_done)   retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
